// File: rtl/cfg_self_write_sequencer_if.sv
// Byte-stream input handshake plus the fabric SelfWrite word/strobe port.
// The sequencer uses the slave modport; the bitstream source uses master.
interface cfg_self_write_sequencer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SelfWriteData;
  logic        SelfWriteStrobe;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  SelfWriteData,
    input  SelfWriteStrobe
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output SelfWriteData,
    output SelfWriteStrobe
  );
endinterface

// File: rtl/cfg_self_write_sequencer.sv
// Packs a byte-wide bitstream into big-endian 32-bit words and writes them to the fabric
// through SelfWriteData/SelfWriteStrobe, then releases the user design from reset.
module cfg_self_write_sequencer #(
  parameter int unsigned MAX_BITBYTES   = 16384,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned RELEASE_CYCLES = 100
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       start,
  input  logic [14:0]                byte_count,
  input  logic                       abort,
  cfg_self_write_sequencer_if.slave  bus,
  output logic                       busy,
  output logic                       done,
  output logic                       user_resetn,
  output logic [12:0]                words_written
);

  localparam int unsigned CNT_MAX_SH = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_MAX    = (CNT_MAX_SH > RELEASE_CYCLES) ? CNT_MAX_SH : RELEASE_CYCLES;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam int unsigned WW_MAX     = 4096;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FILL    = 3'd1;
  localparam logic [2:0] S_SETUP   = 3'd2;
  localparam logic [2:0] S_STROBE  = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]       state, state_d;
  logic [31:0]      word, word_d;
  logic [1:0]       lane, lane_d;
  logic [14:0]      bytes_left, bytes_left_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [31:0]      data_d;
  logic             strobe_d, busy_d, done_d, user_resetn_d;
  logic [12:0]      words_written_d;
  logic             in_ready_c;
  logic [14:0]      clamped_count_c;
  logic [31:0]      packed_word_c, justified_word_c;

  assign in_ready_c      = (state == S_FILL) && (bytes_left != 15'd0);
  assign bus.in_ready    = in_ready_c;
  assign clamped_count_c = (byte_count > 15'(MAX_BITBYTES)) ? 15'(MAX_BITBYTES) : byte_count;
  assign packed_word_c   = {word[23:0], bus.in_data};

  // A short final word is shifted up so its first byte still lands in [31:24].
  always_comb begin
    justified_word_c = packed_word_c;
    case (lane)
      2'd0:    justified_word_c = {packed_word_c[7:0], 24'h0};
      2'd1:    justified_word_c = {packed_word_c[15:0], 16'h0};
      2'd2:    justified_word_c = {packed_word_c[23:0], 8'h0};
      default: justified_word_c = packed_word_c;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state               <= S_IDLE;
      word                <= '0;
      lane                <= '0;
      bytes_left          <= '0;
      cnt                 <= '0;
      bus.SelfWriteData   <= '0;
      bus.SelfWriteStrobe <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      user_resetn         <= 1'b0;
      words_written       <= '0;
    end else begin
      state               <= state_d;
      word                <= word_d;
      lane                <= lane_d;
      bytes_left          <= bytes_left_d;
      cnt                 <= cnt_d;
      bus.SelfWriteData   <= data_d;
      bus.SelfWriteStrobe <= strobe_d;
      busy                <= busy_d;
      done                <= done_d;
      user_resetn         <= user_resetn_d;
      words_written       <= words_written_d;
    end
  end

  // Next state and next registered outputs; strobe is set on entry to STROBE so it lasts one cycle.
  always_comb begin
    state_d         = state;
    word_d          = word;
    lane_d          = lane;
    bytes_left_d    = bytes_left;
    cnt_d           = cnt;
    data_d          = bus.SelfWriteData;
    strobe_d        = 1'b0;
    busy_d          = busy;
    done_d          = done;
    user_resetn_d   = user_resetn;
    words_written_d = words_written;

    if (abort) begin
      state_d       = S_IDLE;
      word_d        = '0;
      lane_d        = '0;
      cnt_d         = '0;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      user_resetn_d = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            bytes_left_d    = clamped_count_c;
            words_written_d = '0;
            word_d          = '0;
            lane_d          = '0;
            cnt_d           = '0;
            busy_d          = 1'b1;
            done_d          = 1'b0;
            user_resetn_d   = 1'b0;
            state_d         = (clamped_count_c == 15'd0) ? S_RELEASE : S_FILL;
          end
        end
        S_FILL: begin
          if (bus.in_valid && in_ready_c) begin
            word_d       = packed_word_c;
            lane_d       = lane + 2'd1;
            bytes_left_d = bytes_left - 15'd1;
            if ((lane == 2'd3) || (bytes_left == 15'd1)) begin
              data_d  = justified_word_c;
              word_d  = '0;
              lane_d  = '0;
              cnt_d   = '0;
              state_d = S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
            cnt_d    = '0;
            strobe_d = 1'b1;
            state_d  = S_STROBE;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        S_STROBE: begin
          cnt_d   = '0;
          state_d = S_HOLD;
          if (words_written != 13'(WW_MAX)) words_written_d = words_written + 13'd1;
        end
        S_HOLD: begin
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = (bytes_left != 15'd0) ? S_FILL : S_RELEASE;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (cnt == CNT_W'(RELEASE_CYCLES - 1)) begin
            cnt_d         = '0;
            state_d       = S_DONE;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            user_resetn_d = 1'b1;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_self_write_sequencer.sv
// Randomized bench for cfg_self_write_sequencer: expected words, strobe timing and
// release latency come from a byte-level model of the load.
module tb_cfg_self_write_sequencer;
  localparam int unsigned SETUP_CYC = 2;
  localparam int unsigned HOLD_CYC  = 2;
  localparam int unsigned REL_CYC   = 100;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [14:0] byte_count = '0;
  logic        busy, done, user_resetn;
  logic [12:0] words_written;

  cfg_self_write_sequencer_if bus();

  cfg_self_write_sequencer #(
    .MAX_BITBYTES  (16384),
    .SETUP_CYCLES  (SETUP_CYC),
    .HOLD_CYCLES   (HOLD_CYC),
    .RELEASE_CYCLES(REL_CYC)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .start        (start),
    .byte_count   (byte_count),
    .abort        (abort),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .user_resetn  (user_resetn),
    .words_written(words_written)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Strobe monitor: captures written words and checks setup/hold stability and strobe width.
  logic [31:0] got_q[$];
  int          strobe_cyc[$];
  logic [31:0] hist1 = '0, hist2 = '0, hold_word = '0;
  int          hold_left = 0;
  logic        prev_strobe = 1'b0;

  always @(negedge CLK) begin
    if (reset) begin
      hold_left   = 0;
      prev_strobe = 1'b0;
      hist1       = '0;
      hist2       = '0;
    end else begin
      if (bus.SelfWriteStrobe) begin
        check("strobe_one_cycle", 32'(prev_strobe), 32'd0);
        check("setup_stable_m1", bus.SelfWriteData, hist1);
        check("setup_stable_m2", bus.SelfWriteData, hist2);
        got_q.push_back(bus.SelfWriteData);
        strobe_cyc.push_back(cyc_cnt);
        hold_left = HOLD_CYC;
        hold_word = bus.SelfWriteData;
      end else if (hold_left > 0) begin
        check("hold_stable", bus.SelfWriteData, hold_word);
        hold_left--;
      end
      if (bus.in_ready) check("in_ready_only_fill", {30'd0, busy, bus.SelfWriteStrobe}, 32'd2);
      prev_strobe = bus.SelfWriteStrobe;
      hist2       = hist1;
      hist1       = bus.SelfWriteData;
    end
  end

  logic [7:0] stim [64];

  // Big-endian packing of the byte stream, zero-padded past the end.
  function automatic logic [31:0] exp_word(input int n, input int w);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++) begin
      r = r << 8;
      if (4 * w + b < n) r[7:0] = stim[4 * w + b];
    end
    return r;
  endfunction

  task automatic run_load(input string name, input int n, input int gap_pct,
                          input int abort_at, input bit poke_start);
    int idx = 0;
    int guard = 0;
    int c0;
    int exp_words;
    bit acc;
    got_q.delete();
    strobe_cyc.delete();
    @(negedge CLK);
    start      = 1'b1;
    byte_count = 15'(n);
    @(negedge CLK);
    start = 1'b0;
    c0    = cyc_cnt;
    check({name, "_busy_after_start"}, 32'(busy), 32'd1);
    while (idx < n && guard < 2000) begin
      if (abort_at >= 0 && idx == abort_at) break;
      bus.in_valid = ($urandom_range(0, 99) >= gap_pct);
      bus.in_data  = stim[idx];
      acc = bus.in_valid && bus.in_ready;
      @(negedge CLK);
      guard++;
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    if (abort_at >= 0) begin
      exp_words = abort_at / 4 - 1;
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      check({name, "_abort_outs"}, {28'd0, busy, done, user_resetn, bus.SelfWriteStrobe}, 32'd0);
      repeat (20) @(negedge CLK);
      check({name, "_idle_after_abort"}, 32'(busy), 32'd0);
    end else begin
      exp_words = (n + 3) / 4;
      guard = 0;
      while (!done && guard < 500) begin
        start = poke_start && (guard == 50);
        @(negedge CLK);
        guard++;
      end
      start = 1'b0;
      check({name, "_done"}, {29'd0, done, user_resetn, busy}, 32'd6);
      if (n == 0)
        check({name, "_release_time"}, 32'(cyc_cnt - c0), 32'(REL_CYC));
      else if (strobe_cyc.size() > 0)
        check({name, "_release_time"}, 32'(cyc_cnt - strobe_cyc[$]), 32'(1 + HOLD_CYC + REL_CYC));
      if (gap_pct == 0 && n >= 8 && strobe_cyc.size() >= 2)
        check({name, "_word_period"}, 32'(strobe_cyc[1] - strobe_cyc[0]), 32'(4 + SETUP_CYC + 1 + HOLD_CYC));
    end
    check({name, "_n_strobes"}, 32'(got_q.size()), 32'(exp_words));
    check({name, "_words_written"}, 32'(words_written), 32'(exp_words));
    for (int w = 0; w < exp_words && w < got_q.size(); w++)
      check($sformatf("%s_word%0d", name, w), got_q[w], exp_word(n, w));
  endtask

  initial begin
    int guard;
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1;
    check("reset_outs", {26'd0, busy, done, user_resetn, bus.SelfWriteStrobe, bus.in_ready, 1'b0}, 32'd0);
    repeat (3) @(negedge CLK);
    check("reset_data", bus.SelfWriteData, 32'd0);
    check("reset_ww", 32'(words_written), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 8; i++) stim[i] = 8'(i + 1);
    run_load("t1", 8, 0, -1, 1'b0);

    stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC;
    stim[3] = 8'hDD; stim[4] = 8'hEE; stim[5] = 8'hFF;
    run_load("t2", 6, 0, -1, 1'b0);

    for (int i = 0; i < 16; i++) stim[i] = 8'($urandom);
    run_load("t3", 16, 40, -1, 1'b0);

    for (int i = 0; i < 12; i++) stim[i] = 8'($urandom);
    run_load("t4", 12, 0, 8, 1'b0);
    run_load("t4_reload", 12, 30, -1, 1'b0);

    // Reset asserted between edges while the strobe is high.
    @(negedge CLK);
    start      = 1'b1;
    byte_count = 15'd8;
    @(negedge CLK);
    start = 1'b0;
    guard = 0;
    while (!bus.SelfWriteStrobe && guard < 60) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h5A;
      @(negedge CLK);
      guard++;
    end
    bus.in_valid = 1'b0;
    check("t5_strobe_seen", 32'(bus.SelfWriteStrobe), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_ctrl", {29'd0, bus.SelfWriteStrobe, busy, bus.in_ready}, 32'd0);
    check("t5_async_data", bus.SelfWriteData, 32'd0);
    @(negedge CLK);
    #2 reset = 1'b0;
    repeat (3) @(negedge CLK);
    check("t5_idle_after", {29'd0, busy, done, bus.SelfWriteStrobe}, 32'd0);

    run_load("t6", 0, 0, -1, 1'b1);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
      run_load($sformatf("rnd%0d", r), n, $urandom_range(0, 50), -1, 1'b0);
    end

    @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    check("abort_in_done", {29'd0, busy, done, user_resetn}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
